// File: rtl/bench_seq_pkg.sv
// Shared opcodes, FSM encodings and default widths for the bench command sequencer.
package bench_seq_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ATTR_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = 4;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_INIT = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PHASE   = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic load;
    logic init;
    logic neg;
    logic oe;
  } sig_t;

  // Bench control levels driven while an op is in its phase.
  function automatic sig_t op_pattern(input logic [1:0] op, input logic neg);
    sig_t s;
    s = '0;
    case (op)
      OP_INIT: begin
        s.load = 1'b1;
        s.init = 1'b1;
      end
      OP_LOAD: begin
        s.load = 1'b1;
        s.neg  = neg;
      end
      OP_READ: s.oe = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bench_seq_cnt.sv
// Loadable down-counter with zero flag; sets the phase length of a command.
module bench_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Saturates at zero so an all-ones load yields exactly 2^W phase cycles.
  always_ff @(posedge clk) begin
    if (RST)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bench_cmd_sequencer.sv
// Command-driven initiator for the bench control interface (NOP/INIT/LOAD/READ).
// Define BENCH_SEQ_ATTR_EN to drive attr_in from cmd_attr during PHASE/CAPTURE.
module bench_cmd_sequencer
  import bench_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ATTR_WIDTH = DEF_ATTR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_neg,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ATTR_WIDTH-1:0] cmd_attr,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  seq_state_t state, state_nxt;
  logic accept;
  logic cnt_zero;

  logic [1:0]            op_q;
  logic                  neg_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [1:0]            op_n;
  logic                  neg_n;
  logic [DATA_WIDTH-1:0] data_n;

  sig_t                  sig_d, sig_q;
  logic [DATA_WIDTH-1:0] data_d, data_q_out;
  logic [ATTR_WIDTH-1:0] attr_d, attr_q_out;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  bench_seq_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk      (clk),
    .RST      (RST),
    .load     (accept),
    .load_val (cmd_cnt),
    .dec      (state == ST_PHASE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      op_q   <= OP_NOP;
      neg_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op;
      neg_q  <= cmd_neg;
      data_q <= cmd_data;
    end
  end

`ifdef BENCH_SEQ_ATTR_EN
  logic [ATTR_WIDTH-1:0] attr_q;
  logic [ATTR_WIDTH-1:0] attr_n;

  always_ff @(posedge clk) begin
    if (RST)
      attr_q <= '0;
    else if (accept)
      attr_q <= cmd_attr;
  end

  assign attr_n = accept ? cmd_attr : attr_q;
`else
  logic unused_attr;
  assign unused_attr = ^cmd_attr;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (RST)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_PHASE;
      ST_PHASE:   if (cnt_zero) state_nxt = (op_q == OP_READ) ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bench levels
  // line up with the state they belong to; on accept the fresh command fields
  // are used since the latch only updates on this same edge.
  always_comb begin
    op_n   = accept ? cmd_op   : op_q;
    neg_n  = accept ? cmd_neg  : neg_q;
    data_n = accept ? cmd_data : data_q;
    sig_d  = '0;
    data_d = '0;
    attr_d = '0;
    if (state_nxt == ST_PHASE) begin
      sig_d = op_pattern(op_n, neg_n);
      if ((op_n == OP_INIT) || (op_n == OP_LOAD))
        data_d = data_n;
    end
`ifdef BENCH_SEQ_ATTR_EN
    if (state_nxt != ST_IDLE)
      attr_d = attr_n;
`endif
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sig_q      <= '0;
      data_q_out <= '0;
      attr_q_out <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      sig_q      <= sig_d;
      data_q_out <= data_d;
      attr_q_out <= attr_d;
      rsp_valid  <= (state == ST_CAPTURE);
      if (state == ST_CAPTURE)
        rsp_data <= data_out;
    end
  end

  assign signal_load = sig_q.load;
  assign signal_init = sig_q.init;
  assign signal_neg  = sig_q.neg;
  assign signal_oe   = sig_q.oe;
  assign data_in     = data_q_out;
  assign attr_in     = attr_q_out;

endmodule

// File: tb/tb_bench_cmd_sequencer.sv
// Randomized self-checking bench for bench_cmd_sequencer against a cycle-trace model.
module tb_bench_cmd_sequencer;
  import bench_seq_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ATTR_WIDTH;
  localparam int CW = DEF_CNT_WIDTH;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic          cmd_neg = 1'b0;
  logic [CW-1:0] cmd_cnt = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] cmd_attr = '0;
  logic          signal_load, signal_init, signal_neg, signal_oe;
  logic [DW-1:0] data_in;
  logic [AW-1:0] attr_in;
  logic [DW-1:0] data_out = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;

  bench_cmd_sequencer #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_neg(cmd_neg), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .cmd_attr(cmd_attr), .signal_load(signal_load), .signal_init(signal_init),
    .signal_neg(signal_neg), .signal_oe(signal_oe), .data_in(data_in),
    .attr_in(attr_in), .data_out(data_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // One expected output record per clock cycle.
  typedef struct packed {
    logic          ready;
    logic          busy;
    logic [3:0]    sig;   // {load, init, neg, oe}
    logic [DW-1:0] din;
    logic [AW-1:0] attr;
    logic          cap;
    logic          rsp;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int acc_cnt = 0, rsp_seen = 0, tmo_cnt = 0, exp_rsp_total = 0;
  logic mon_en = 1'b0, fin_req = 1'b0, fin_done = 1'b0, rand_dout = 1'b0;
  logic [DW-1:0] cap_val = '0, exp_rsp_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Expected trace of one accepted command: cnt+1 phase cycles, and for READ
  // a capture cycle followed by a one-cycle response in IDLE.
  task automatic push_cmd(input logic [1:0] op, input logic neg, input logic [CW-1:0] cnt,
                          input logic [DW-1:0] d, input logic [AW-1:0] a);
    exp_t e;
    logic [AW-1:0] ea;
`ifdef BENCH_SEQ_ATTR_EN
    ea = a;
`else
    ea = '0;
`endif
    for (int i = 0; i <= int'(cnt); i++) begin
      e = '0;
      e.busy = 1'b1;
      e.attr = ea;
      case (op)
        2'd1: begin e.sig = 4'b1100; e.din = d; end
        2'd2: begin e.sig = {1'b1, 1'b0, neg, 1'b0}; e.din = d; end
        2'd3: e.sig = 4'b0001;
        default: ;
      endcase
      exp_q.push_back(e);
    end
    if (op == 2'd3) begin
      e = '0; e.busy = 1'b1; e.attr = ea; e.cap = 1'b1;
      exp_q.push_back(e);
      e = '0; e.ready = 1'b1; e.rsp = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin e = '0; e.ready = 1'b1; end
        if (e.cap) cap_val = data_out;
        if (e.rsp) exp_rsp_data = cap_val;
        if (rsp_valid === 1'b1) rsp_seen++;
        chk("cmd_ready", cmd_ready, e.ready);
        chk("busy", busy, e.busy);
        chk("signals", {signal_load, signal_init, signal_neg, signal_oe}, e.sig);
        chk("data_in", data_in, e.din);
        chk("attr_in", attr_in, e.attr);
        chk("rsp_valid", rsp_valid, e.rsp);
        chk("rsp_data", rsp_data, exp_rsp_data);
        if (RST) begin
          exp_q.delete();
          exp_rsp_data = '0;
        end else if (cmd_valid && e.ready) begin
          push_cmd(cmd_op, cmd_neg, cmd_cnt, cmd_data, cmd_attr);
          acc_cnt++;
        end
        if (fin_req && !fin_done) begin
          chk("rsp_total", rsp_seen, exp_rsp_total);
          chk("accept_timeouts", tmo_cnt, 0);
          chk("queue_drained", exp_q.size(), 0);
          fin_done = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_dout) data_out = DW'($urandom);
  endtask

  // Offers a command and returns just after the edge that accepts it; cmd_valid
  // stays high so a following send() is back-to-back.
  task automatic send(input logic [1:0] op, input logic neg, input logic [CW-1:0] cnt,
                      input logic [DW-1:0] d, input logic [AW-1:0] a);
    int snap, w;
    cmd_op = op; cmd_neg = neg; cmd_cnt = cnt; cmd_data = d; cmd_attr = a;
    cmd_valid = 1'b1;
    snap = acc_cnt;
    w = 0;
    while (acc_cnt == snap && w < 64) begin
      step();
      w++;
    end
    if (acc_cnt == snap) begin
      tmo_cnt++;
      cmd_valid = 1'b0;
    end else if (op == OP_READ) begin
      exp_rsp_total++;
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int w;
    RST = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    step();
    RST = 1'b0;
    idle(2);

    // Directed cases
    send(OP_INIT, 1'b0, 4'd0, 8'd25, 4'h3);
    idle(3);
    send(OP_LOAD, 1'b1, 4'd2, 8'd5, 4'hA);
    idle(5);
    data_out = 8'h3A;
    send(OP_READ, 1'b0, 4'd9, 8'hFF, 4'h6);
    idle(14);
    send(OP_INIT, 1'b0, 4'd0, 8'd25, 4'h1);
    send(OP_NOP, 1'b0, 4'd9, 8'h77, 4'h2);
    send(OP_READ, 1'b0, 4'd9, 8'h00, 4'h4);
    idle(14);
    send(OP_LOAD, 1'b0, 4'd15, 8'hC3, 4'hF);
    idle(18);

    // Reset during the 5th oe cycle of a READ aborts it with no response
    send(OP_READ, 1'b0, 4'd9, 8'h00, 4'h9);
    cmd_valid = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    exp_rsp_total--;
    step();
    RST = 1'b0;
    idle(3);

    // Randomized commands, gaps and bench data
    rand_dout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [CW-1:0] c;
      case ($urandom_range(0, 5))
        0: c = '0;
        1: c = '1;
        default: c = CW'($urandom_range(0, 6));
      endcase
      send(2'($urandom_range(0, 3)), 1'($urandom), c, DW'($urandom), AW'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(24);

    fin_req = 1'b1;
    w = 0;
    while (!fin_done && w < 10) begin
      step();
      w++;
    end
    if (!fin_done) begin
      n_fail++;
      $display("FAIL final_checks got=not_run want=run");
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
